motor602_uart_tx: RTL



---
 rtl/motor602_uart_pkg.sv | 26 ++
 rtl/motor602_baud_tick.sv | 28 ++
 rtl/motor602_uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/motor602_uart_pkg.sv
// Shared types and helpers for the motor602 telemetry UART transmitter.
// Frame bit count depends on MOTOR602_UART_TX_PARITY_EN.
package motor602_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_t;

  localparam int DATA_BITS = 8;

`ifdef MOTOR602_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Clocks per bit; integer truncation is intended.
  function automatic int calcDiv(input int clkHz, input int baud);
    return clkHz / baud;
  endfunction

endpackage

// File: rtl/motor602_baud_tick.sv
// DIV-modulo bit-period counter with synchronous clear and terminal-count strobe.
module motor602_baud_tick #(
  parameter int DIV = 434
) (
  input  logic clkI,
  input  logic nRstI,
  input  logic clrI,
  output logic tickO
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tickO = !clrI && (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cnt <= '0;
    end else if (clrI || tickO) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor602_uart_tx.sv
// Telemetry UART transmitter: one-byte holding buffer, 8N1 framing, or 8E1
// when MOTOR602_UART_TX_PARITY_EN is defined.
module motor602_uart_tx
  import motor602_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic [7:0] dataI,
  input  logic       validI,
  output logic       readyO,
  output logic       uTxO,
  output logic       busyO,
  output logic       clkUtxO
);

  localparam int DIV = calcDiv(CLK_HZ, BAUD);

  txState_t   state;
  logic [7:0] holdBuf;
  logic [7:0] shiftReg;
  logic [2:0] bitIdx;
  logic       isIdle;
  logic       bitTick;
  logic       loadShift;
`ifdef MOTOR602_UART_TX_PARITY_EN
  logic       parityBit;
`endif

  assign isIdle  = (state == ST_IDLE);
  assign busyO   = !isIdle;
  assign clkUtxO = bitTick;

  // The buffer moves to the shifter from IDLE, or at the end of STOP for abutting frames.
  assign loadShift = !readyO && (isIdle || ((state == ST_STOP) && bitTick));

  motor602_baud_tick #(.DIV(DIV)) uBaudTick (
    .clkI  (clkI),
    .nRstI (nRstI),
    .clrI  (isIdle),
    .tickO (bitTick)
  );

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state     <= ST_IDLE;
      uTxO      <= 1'b1;
      readyO    <= 1'b1;
      // NOTE: data registers are reset too, so nothing downstream ever observes X after reset.
      holdBuf   <= '0;
      shiftReg  <= '0;
      bitIdx    <= '0;
`ifdef MOTOR602_UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      if (validI && readyO) begin
        holdBuf <= dataI;
        readyO  <= 1'b0;
      end else if (loadShift) begin
        readyO <= 1'b1;
      end

      if (loadShift) begin
        state    <= ST_START;
        uTxO     <= 1'b0;
        shiftReg <= holdBuf;
`ifdef MOTOR602_UART_TX_PARITY_EN
        parityBit <= ^holdBuf;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            uTxO <= 1'b1;
          end
          ST_START: begin
            if (bitTick) begin
              state  <= ST_DATA;
              bitIdx <= '0;
              uTxO   <= shiftReg[0];
            end
          end
          ST_DATA: begin
            if (bitTick) begin
              if (bitIdx == 3'(DATA_BITS - 1)) begin
`ifdef MOTOR602_UART_TX_PARITY_EN
                state <= ST_PARITY;
                uTxO  <= parityBit;
`else
                state <= ST_STOP;
                uTxO  <= 1'b1;
`endif
              end else begin
                bitIdx   <= bitIdx + 3'd1;
                shiftReg <= shiftReg >> 1;
                uTxO     <= shiftReg[1];
              end
            end
          end
`ifdef MOTOR602_UART_TX_PARITY_EN
          ST_PARITY: begin
            if (bitTick) begin
              state <= ST_STOP;
              uTxO  <= 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (bitTick) begin
              state <= ST_IDLE;
              uTxO  <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            uTxO  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
